// File: rtl/audio_level_meter_if.sv
// Audio level meter bus: sample strobe in, envelope / bar / clip out.
//
// Handshake: sample_valid is a one-cycle strobe qualifying sample_in on the
// same rising edge. There is no ready; the meter accepts one sample on every
// cycle. level, bar and clip are level outputs that hold their value between
// updates. level reflects a strobe 2 edges later, and bar/clip reflect it
// 3 edges later.
interface audio_level_meter_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_LEDS = 7
);
  logic                       sample_valid;
  logic signed [DATA_W-1:0]   sample_in;
  logic        [DATA_W-2:0]   level;
  logic        [NUM_LEDS-1:0] bar;
  logic                       clip;

  // The source drives samples and observes the meter outputs.
  modport master (
    output sample_valid,
    output sample_in,
    input  level,
    input  bar,
    input  clip
  );

  // The meter consumes samples and drives the outputs.
  modport slave (
    input  sample_valid,
    input  sample_in,
    output level,
    output bar,
    output clip
  );
endinterface

// File: rtl/audio_level_meter.sv
// Peak-envelope VU meter. The envelope has instant attack, a hold period
// counted in samples, and exponential decay. It also drives a 6 dB/step
// thermometer bar and a sticky clip flag. The pipeline has three stages:
// magnitude, envelope update, and display registers.
module audio_level_meter #(
  parameter int DATA_W       = 16,
  parameter int NUM_LEDS     = 7,
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 6,
  parameter int CLIP_HOLD    = 24000
) (
  input  logic                 clk,
  input  logic                 rst,
  audio_level_meter_if.slave   bus
);

  localparam int AW = DATA_W - 1;
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam int CW = $clog2(CLIP_HOLD + 1);

  localparam logic [AW-1:0]     FULL_SCALE = {AW{1'b1}};
  localparam logic [HW-1:0]     HOLD_INIT  = HW'(HOLD_SAMPLES);
  localparam logic [CW-1:0]     CLIP_INIT  = CW'(CLIP_HOLD);
  localparam logic [DATA_W-1:0] MOST_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

  // Stage 1 registers.
  logic [AW-1:0] a_q;
  logic          v1_q;

  // Stage 2 registers.
  logic [AW-1:0] env_q;
  logic [HW-1:0] hold_cnt_q;
  logic [CW-1:0] clip_cnt_q;

  // Stage 3 registers.
  logic [NUM_LEDS-1:0] bar_q;
  logic                clip_q;

  // Combinational intermediates.
  logic [AW-1:0]       abs_c;
  logic [DATA_W-1:0]   neg_c;
  logic [AW-1:0]       decay_d_c;
  logic [AW-1:0]       decay_step_c;
  logic [AW-1:0]       env_d;
  logic [HW-1:0]       hold_cnt_d;
  logic [CW-1:0]       clip_cnt_d;
  logic [NUM_LEDS-1:0] bar_c;
  logic [AW-1:0]       thr_c;

  // Saturating magnitude: the most negative code has no positive twin,
  // so it maps onto full scale.
  always_comb begin
    abs_c = '0;
    neg_c = -bus.sample_in;
    if (bus.sample_in == MOST_NEG) begin
      abs_c = FULL_SCALE;
    end else if (bus.sample_in[DATA_W-1]) begin
      abs_c = neg_c[AW-1:0];
    end else begin
      abs_c = bus.sample_in[AW-1:0];
    end
  end

  // Stage 1: register the magnitude and flag that a sample is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= bus.sample_valid;
      if (bus.sample_valid) begin
        a_q <= abs_c;
      end
    end
  end

  // Envelope and counter next state. When the shifted decay amount reaches
  // zero, the envelope still steps down by one, so it always lands on 0.
  always_comb begin
    env_d        = env_q;
    hold_cnt_d   = hold_cnt_q;
    clip_cnt_d   = clip_cnt_q;
    decay_d_c    = env_q >> DECAY_SHIFT;
    decay_step_c = (decay_d_c != '0) ? decay_d_c
                                     : {{(AW-1){1'b0}}, (env_q != '0)};
    if (a_q >= env_q) begin
      env_d      = a_q;
      hold_cnt_d = HOLD_INIT;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end else begin
      env_d = env_q - decay_step_c;
    end
    if (a_q == FULL_SCALE) begin
      clip_cnt_d = CLIP_INIT;
    end else if (clip_cnt_q != '0) begin
      clip_cnt_d = clip_cnt_q - 1'b1;
    end
  end

  // Stage 2: update the envelope only on samples, so hold and decay count
  // samples rather than clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_q      <= '0;
      hold_cnt_q <= '0;
      clip_cnt_q <= '0;
    end else if (v1_q) begin
      env_q      <= env_d;
      hold_cnt_q <= hold_cnt_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  // Thermometer decode. Segment k lights at 2^(DATA_W-2-(NUM_LEDS-1-k)),
  // which places the top segment at 2^(DATA_W-2).
  always_comb begin
    bar_c = '0;
    thr_c = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      thr_c = '0;
      thr_c[DATA_W-2-(NUM_LEDS-1-k)] = 1'b1;
      bar_c[k] = (env_q >= thr_c);
    end
  end

  // Stage 3: register the display outputs from the envelope and clip state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      bar_q  <= bar_c;
      clip_q <= (clip_cnt_q != '0);
    end
  end

  assign bus.level = env_q;
  assign bus.bar   = bar_q;
  assign bus.clip  = clip_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter. A reference model turns each issued sample
// into expected level / bar / clip values, which go into queues. A monitor
// pops these values and compares them when the matching outputs become due.
module tb_audio_level_meter;

  localparam int DATA_W       = 16;
  localparam int NUM_LEDS     = 7;
  localparam int HOLD_SAMPLES = 2;
  localparam int DECAY_SHIFT  = 1;
  localparam int CLIP_HOLD    = 3;

  logic clk;
  logic rst;

  audio_level_meter_if #(.DATA_W(DATA_W), .NUM_LEDS(NUM_LEDS)) bus ();

  audio_level_meter #(
    .DATA_W(DATA_W), .NUM_LEDS(NUM_LEDS), .HOLD_SAMPLES(HOLD_SAMPLES),
    .DECAY_SHIFT(DECAY_SHIFT), .CLIP_HOLD(CLIP_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-2:0] exp_q[$];     // expected level per sample
  logic [NUM_LEDS:0] exp_bc_q[$];  // expected {clip, bar} per sample

  // Reference model state in plain integers.
  int m_env  = 0;
  int m_hold = 0;
  int m_clip = 0;

  function automatic void chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_env  = 0;
    m_hold = 0;
    m_clip = 0;
    exp_q.delete();
    exp_bc_q.delete();
  endfunction

  // The bar lights every segment whose threshold the envelope reaches.
  // Thresholds double from 256 up to 16384.
  function automatic int model_bar(int env);
    int n;
    int thr;
    n   = 0;
    thr = 256;
    while (n < NUM_LEDS && env >= thr) begin
      n++;
      thr = thr * 2;
    end
    return (1 << n) - 1;
  endfunction

  function automatic void model_step(int s);
    int a;
    int d;
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    if (a >= m_env) begin
      m_env  = a;
      m_hold = HOLD_SAMPLES;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end else begin
      d = m_env / (1 << DECAY_SHIFT);
      m_env = m_env - ((d > 0) ? d : 1);
    end
    if (a == 32767) m_clip = CLIP_HOLD;
    else if (m_clip > 0) m_clip = m_clip - 1;
    exp_q.push_back(m_env[DATA_W-2:0]);
    exp_bc_q.push_back({(m_clip > 0), model_bar(m_env)[NUM_LEDS-1:0]});
  endfunction

  // ---------------- driver tasks ----------------
  // Present one sample for a single edge, then idle for gap edges.
  task automatic drive(input int s, input int gap);
    bus.sample_in    = s[DATA_W-1:0];
    bus.sample_valid = 1'b1;
    model_step(s);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset_level", int'(bus.level), 0);
    chk("reset_bar",   int'(bus.bar),   0);
    chk("reset_clip",  int'(bus.clip),  0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  // Strobe history: bit 1 marks that level is due, and bit 2 marks that
  // bar/clip are due.
  logic [2:0] hist;

  always @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= {hist[1:0], bus.sample_valid};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hist[1]) begin
        if (exp_q.size() == 0) chk("level_pending", 0, 1);
        else chk("sb_level", int'(bus.level), int'(exp_q.pop_front()));
      end
      if (hist[2]) begin
        if (exp_bc_q.size() == 0) chk("barclip_pending", 0, 1);
        else begin
          logic [NUM_LEDS:0] e;
          e = exp_bc_q.pop_front();
          chk("sb_bar",  int'(bus.bar),  int'(e[NUM_LEDS-1:0]));
          chk("sb_clip", int'(bus.clip), int'(e[NUM_LEDS]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int lv3[4]  = '{16384, 16384, 8192, 4096};
  int lv4[7]  = '{3, 3, 3, 2, 1, 0, 0};
  int clp5[3] = '{1, 1, 0};

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    rst              = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Idle: nothing may move without strobes.
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_level", int'(bus.level), 0);
    chk("idle_bar",   int'(bus.bar),   0);
    chk("idle_clip",  int'(bus.clip),  0);

    // Half-scale attack.
    drive(16384, 3);
    chk("attack_level", int'(bus.level), 16384);
    chk("attack_bar",   int'(bus.bar),   7'b1111111);
    chk("attack_clip",  int'(bus.clip),  0);

    // Hold for two samples, then halve.
    for (int i = 0; i < 4; i++) begin
      drive(0, 3);
      chk("hold_decay_level", int'(bus.level), lv3[i]);
      if (i == 2) chk("decay_bar", int'(bus.bar), 7'b0111111);
    end

    // Small value decays to exactly zero.
    do_reset();
    drive(3, 3);
    chk("floor_level", int'(bus.level), lv4[0]);
    for (int i = 1; i < 7; i++) begin
      drive(0, 3);
      chk("floor_level", int'(bus.level), lv4[i]);
    end

    // Full-scale negative saturates and lights clip.
    drive(-32768, 3);
    chk("sat_level", int'(bus.level), 32767);
    chk("sat_clip",  int'(bus.clip),  1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 3);
      chk("clip_hold", int'(bus.clip), clp5[i]);
    end
    drive(32767, 3);
    chk("pos_clip", int'(bus.clip), 1);

    // Back-to-back samples, then a reset mid-stream.
    do_reset();
    drive(100, 0);
    drive(5000, 0);
    drive(300, 1);
    @(negedge clk);
    chk("b2b_level", int'(bus.level), 5000);
    #1;
    do_reset();
    drive(200, 3);
    chk("post_reset_level", int'(bus.level), 200);

    // Random traffic, biased toward full scale and silence.
    for (int i = 0; i < 400; i++) begin
      int sel;
      int s;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       s = -32768;
        1:       s = 32767;
        2, 3, 4: s = 0;
        5:       s = $urandom_range(0, 600) - 300;
        default: s = $urandom_range(0, 65535) - 32768;
      endcase
      drive(s, $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("drain_level", exp_q.size(), 0);
    chk("drain_barclip", exp_bc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
